// File: rtl/cacop_pkg.sv
// Shared definitions for the L1D CACOP responder: op codes, FSM states and
// tag-entry field offsets.
package cacop_pkg;

   localparam logic [1:0] CACOP_STORE_TAG = 2'd0;
   localparam logic [1:0] CACOP_INDEX_INV = 2'd1;
   localparam logic [1:0] CACOP_HIT_INV   = 2'd2;
   localparam logic [1:0] CACOP_RSVD      = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_XLATE   = 3'd1,
      S_TAG_RD  = 3'd2,
      S_TAG_CHK = 3'd3,
      S_WB_REQ  = 3'd4,
      S_WB_WAIT = 3'd5,
      S_TAG_WR  = 3'd6,
      S_DONE    = 3'd7
   } state_t;

   // Status bit positions measured upward from the top of the tag field.
   localparam int VALID_BIT = 1;
   localparam int DIRTY_BIT = 0;

endpackage

// File: rtl/l1d_cacop_responder_if.sv
// Bundle of the CACOP request handshake, TLB port, tag-array port and
// writeback-engine port. slave = responder side, master = surroundings.
interface l1d_cacop_responder_if #(
   parameter int WAYS    = 2,
   parameter int INDEX_W = 6,
   parameter int TAG_W   = 20
);
   localparam int WAY_W = $clog2(WAYS);

   logic                      cacop_en;
   logic [1:0]                cacop_code;
   logic [31:0]               cacop_vaddr;
   logic                      cacop_ready;
   logic                      cacop_complete;
   logic [6:0]                cacop_exp;
   logic                      tlb_req;
   logic [31:0]               tlb_vaddr;
   logic                      tlb_valid;
   logic [31:0]               tlb_paddr;
   logic [6:0]                tlb_exp;
   logic                      tag_rd;
   logic [INDEX_W-1:0]        tag_addr;
   logic [WAYS*(TAG_W+2)-1:0] tag_rdata;
   logic [WAYS-1:0]           tag_we;
   logic [TAG_W+1:0]          tag_wdata;
   logic                      wb_req;
   logic [WAY_W-1:0]          wb_way;
   logic [INDEX_W-1:0]        wb_index;
   logic                      wb_ready;
   logic                      wb_done;

   modport slave (
      input  cacop_en, cacop_code, cacop_vaddr,
      output cacop_ready, cacop_complete, cacop_exp,
      output tlb_req, tlb_vaddr,
      input  tlb_valid, tlb_paddr, tlb_exp,
      output tag_rd, tag_addr, tag_we, tag_wdata,
      input  tag_rdata,
      output wb_req, wb_way, wb_index,
      input  wb_ready, wb_done
   );

   modport master (
      output cacop_en, cacop_code, cacop_vaddr,
      input  cacop_ready, cacop_complete, cacop_exp,
      input  tlb_req, tlb_vaddr,
      output tlb_valid, tlb_paddr, tlb_exp,
      input  tag_rd, tag_addr, tag_we, tag_wdata,
      output tag_rdata,
      input  wb_req, wb_way, wb_index,
      output wb_ready, wb_done
   );

endinterface

// File: rtl/cacop_way_sel.sv
// Per-way tag compare with lowest-way priority, plus a per-way valid&dirty
// vector used to decide whether the target line needs a writeback.
module cacop_way_sel
   import cacop_pkg::*;
#(
   parameter int WAYS  = 2,
   parameter int TAG_W = 20
) (
   input  logic [WAYS*(TAG_W+2)-1:0] tag_rdata,
   input  logic [TAG_W-1:0]          cmp_tag,
   output logic                      hit,
   output logic [$clog2(WAYS)-1:0]   way,
   output logic [WAYS-1:0]           vd
);
   localparam int WAY_W = $clog2(WAYS);
   localparam int ENT_W = TAG_W + 2;

   // Scanning from the top way down leaves the lowest matching way selected.
   always_comb begin
      hit = 1'b0;
      way = '0;
      vd  = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         vd[i] = tag_rdata[i*ENT_W + TAG_W + VALID_BIT] &&
                 tag_rdata[i*ENT_W + TAG_W + DIRTY_BIT];
         if (tag_rdata[i*ENT_W + TAG_W + VALID_BIT] &&
             (tag_rdata[i*ENT_W +: TAG_W] == cmp_tag)) begin
            hit = 1'b1;
            way = WAY_W'(i);
         end
      end
   end

endmodule

// File: rtl/l1d_cacop_responder.sv
// L1D-side CACOP responder: optional translation, tag read/check, dirty-line
// writeback and tag invalidation, finishing with a one-cycle complete pulse.
module l1d_cacop_responder
   import cacop_pkg::*;
#(
   parameter int WAYS     = 2,
   parameter int INDEX_W  = 6,
   parameter int OFFSET_W = 6,
   parameter int TAG_W    = 20
) (
   input logic                   clk,
   input logic                   rstn,
   l1d_cacop_responder_if.slave  bus
);
   localparam int WAY_W = $clog2(WAYS);

   state_t             state, state_nxt;
   logic [1:0]         code_q;
   logic [31:0]        vaddr_q;
   logic [TAG_W-1:0]   ptag_q;
   logic [6:0]         exp_q;
   logic [WAY_W-1:0]   way_q;
   logic [INDEX_W-1:0] index;
   logic               hit;
   logic [WAY_W-1:0]   hit_way;
   logic [WAYS-1:0]    way_vd;
   logic [WAY_W-1:0]   tgt_way;
   logic               unused_paddr_lo;

   assign index           = vaddr_q[OFFSET_W +: INDEX_W];
   assign tgt_way         = (code_q == CACOP_HIT_INV) ? hit_way : way_q;
   assign unused_paddr_lo = ^bus.tlb_paddr[31-TAG_W:0];

   cacop_way_sel #(.WAYS(WAYS), .TAG_W(TAG_W)) u_way_sel (
      .tag_rdata (bus.tag_rdata),
      .cmp_tag   (ptag_q),
      .hit       (hit),
      .way       (hit_way),
      .vd        (way_vd)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // way_q starts as the index-op way from vaddr and is overwritten by the
   // resolved target in TAG_CHK, so later states only ever look at way_q.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         code_q  <= '0;
         vaddr_q <= '0;
         ptag_q  <= '0;
         exp_q   <= '0;
         way_q   <= '0;
      end else begin
         case (state)
            S_IDLE: if (bus.cacop_en) begin
               code_q  <= bus.cacop_code;
               vaddr_q <= bus.cacop_vaddr;
               way_q   <= bus.cacop_vaddr[WAY_W-1:0];
               exp_q   <= '0;
            end
            S_XLATE: if (bus.tlb_valid) begin
               if (bus.tlb_exp != 7'd0) exp_q  <= bus.tlb_exp;
               else                     ptag_q <= bus.tlb_paddr[31 -: TAG_W];
            end
            S_TAG_CHK: way_q <= tgt_way;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt          = state;
      bus.cacop_ready    = 1'b0;
      bus.cacop_complete = 1'b0;
      bus.cacop_exp      = '0;
      bus.tlb_req        = 1'b0;
      bus.tlb_vaddr      = vaddr_q;
      bus.tag_rd         = 1'b0;
      bus.tag_addr       = '0;
      bus.tag_we         = '0;
      bus.tag_wdata      = '0;
      bus.wb_req         = 1'b0;
      bus.wb_way         = way_q;
      bus.wb_index       = index;
      case (state)
         S_IDLE: begin
            bus.cacop_ready = 1'b1;
            if (bus.cacop_en) begin
               case (bus.cacop_code)
                  CACOP_STORE_TAG: state_nxt = S_TAG_WR;
                  CACOP_INDEX_INV: state_nxt = S_TAG_RD;
                  CACOP_HIT_INV:   state_nxt = S_XLATE;
                  CACOP_RSVD:      state_nxt = S_DONE;
                  default:         state_nxt = S_DONE;
               endcase
            end
         end
         S_XLATE: begin
            bus.tlb_req = 1'b1;
            if (bus.tlb_valid)
               state_nxt = (bus.tlb_exp != 7'd0) ? S_DONE : S_TAG_RD;
         end
         S_TAG_RD: begin
            bus.tag_rd   = 1'b1;
            bus.tag_addr = index;
            state_nxt    = S_TAG_CHK;
         end
         S_TAG_CHK: begin
            if ((code_q == CACOP_HIT_INV) && !hit) state_nxt = S_DONE;
            else if (way_vd[tgt_way])              state_nxt = S_WB_REQ;
            else                                   state_nxt = S_TAG_WR;
         end
         S_WB_REQ: begin
            bus.wb_req = 1'b1;
            if (bus.wb_ready) state_nxt = S_WB_WAIT;
         end
         S_WB_WAIT: if (bus.wb_done) state_nxt = S_TAG_WR;
         S_TAG_WR: begin
            bus.tag_we[way_q] = 1'b1;
            bus.tag_addr      = index;
            state_nxt         = S_DONE;
         end
         S_DONE: begin
            bus.cacop_complete = 1'b1;
            bus.cacop_exp      = exp_q;
            state_nxt          = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_l1d_cacop_responder.sv
// Directed self-checking bench for l1d_cacop_responder: one task per scenario,
// outputs sampled on the falling clock edge.
module tb_l1d_cacop_responder;

   logic clk = 1'b0;
   logic rstn;
   int   tests_run = 0;
   int   tests_failed = 0;
   int   n_tag_rd = 0;
   int   n_tag_we = 0;
   int   n_wb_req = 0;

   always #5 clk = ~clk;

   l1d_cacop_responder_if #(.WAYS(2), .INDEX_W(6), .TAG_W(20)) bus ();

   l1d_cacop_responder #(.WAYS(2), .INDEX_W(6), .OFFSET_W(6), .TAG_W(20)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   // Activity counters let a scenario assert that a strobe never fired.
   always @(negedge clk) begin
      if (bus.tag_rd === 1'b1)   n_tag_rd++;
      if (bus.tag_we !== 2'b00)  n_tag_we++;
      if (bus.wb_req === 1'b1)   n_wb_req++;
   end

   task automatic do_accept(input logic [1:0] code, input logic [31:0] va);
      @(negedge clk);
      bus.cacop_en = 1'b1; bus.cacop_code = code; bus.cacop_vaddr = va;
      tests_run++; if (bus.cacop_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL accept_ready got %b want 1", bus.cacop_ready); end
      @(negedge clk);
      bus.cacop_en = 1'b0;
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      bus.cacop_en = 0; bus.cacop_code = 0; bus.cacop_vaddr = 0;
      bus.tlb_valid = 0; bus.tlb_paddr = 0; bus.tlb_exp = 0;
      bus.tag_rdata = 0; bus.wb_ready = 0; bus.wb_done = 0;
      repeat (2) @(negedge clk);
      tests_run++; if (bus.cacop_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_ready got %b want 1", bus.cacop_ready); end
      tests_run++; if (bus.cacop_complete !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_complete got %b want 0", bus.cacop_complete); end
      tests_run++; if (bus.cacop_exp !== 7'h00) begin tests_failed++; $display("[TB] FAIL rst_exp got %h want 00", bus.cacop_exp); end
      tests_run++; if ({bus.tlb_req, bus.tag_rd, bus.wb_req} !== 3'b000) begin tests_failed++; $display("[TB] FAIL rst_strobes got %b want 000", {bus.tlb_req, bus.tag_rd, bus.wb_req}); end
      tests_run++; if (bus.tag_we !== 2'b00) begin tests_failed++; $display("[TB] FAIL rst_tag_we got %b want 00", bus.tag_we); end
      tests_run++; if (bus.tlb_vaddr !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_tlb_vaddr got %h want 0", bus.tlb_vaddr); end
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_store_tag;
      int rd0, wb0;
      rd0 = n_tag_rd; wb0 = n_wb_req;
      do_accept(2'd0, 32'h0000_0041);
      tests_run++; if (bus.tag_we !== 2'b10) begin tests_failed++; $display("[TB] FAIL st_tag_we got %b want 10", bus.tag_we); end
      tests_run++; if (bus.tag_addr !== 6'd1) begin tests_failed++; $display("[TB] FAIL st_tag_addr got %0d want 1", bus.tag_addr); end
      tests_run++; if (bus.tag_wdata !== 22'h0) begin tests_failed++; $display("[TB] FAIL st_tag_wdata got %h want 0", bus.tag_wdata); end
      tests_run++; if (bus.cacop_complete !== 1'b0) begin tests_failed++; $display("[TB] FAIL st_early_complete got %b want 0", bus.cacop_complete); end
      @(negedge clk);
      tests_run++; if (bus.cacop_complete !== 1'b1) begin tests_failed++; $display("[TB] FAIL st_complete got %b want 1", bus.cacop_complete); end
      tests_run++; if (bus.cacop_exp !== 7'h00) begin tests_failed++; $display("[TB] FAIL st_exp got %h want 00", bus.cacop_exp); end
      @(negedge clk);
      tests_run++; if ((n_tag_rd - rd0) !== 0 || (n_wb_req - wb0) !== 0) begin tests_failed++; $display("[TB] FAIL st_no_rd_wb got rd=%0d wb=%0d want 0/0", n_tag_rd - rd0, n_wb_req - wb0); end
   endtask

   task automatic test_busy_ignore;
      do_accept(2'd0, 32'h0000_0040);
      bus.cacop_en = 1'b1; bus.cacop_code = 2'd3;
      tests_run++; if (bus.cacop_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL busy_ready got %b want 0", bus.cacop_ready); end
      @(negedge clk);
      bus.cacop_en = 1'b0;
      tests_run++; if (bus.cacop_complete !== 1'b1) begin tests_failed++; $display("[TB] FAIL busy_complete got %b want 1", bus.cacop_complete); end
      @(negedge clk);
      tests_run++; if (bus.cacop_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL busy_idle_ready got %b want 1", bus.cacop_ready); end
      @(negedge clk);
      tests_run++; if (bus.cacop_complete !== 1'b0) begin tests_failed++; $display("[TB] FAIL busy_buffered got complete=%b want 0", bus.cacop_complete); end
   endtask

   task automatic test_index_inv_dirty;
      bus.tag_rdata = {1'b0, 1'b0, 20'h00000, 1'b1, 1'b1, 20'h12345};
      do_accept(2'd1, 32'h0000_0080);
      tests_run++; if (bus.tag_rd !== 1'b1 || bus.tag_addr !== 6'd2) begin tests_failed++; $display("[TB] FAIL ii_tag_rd got rd=%b addr=%0d want 1/2", bus.tag_rd, bus.tag_addr); end
      repeat (2) @(negedge clk);
      tests_run++; if (bus.wb_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL ii_wb_req got %b want 1", bus.wb_req); end
      tests_run++; if (bus.wb_way !== 1'b0 || bus.wb_index !== 6'd2) begin tests_failed++; $display("[TB] FAIL ii_wb_target got way=%0d idx=%0d want 0/2", bus.wb_way, bus.wb_index); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++; if (bus.wb_req !== 1'b1 || bus.wb_index !== 6'd2) begin tests_failed++; $display("[TB] FAIL ii_wb_hold got req=%b idx=%0d want 1/2", bus.wb_req, bus.wb_index); end
      end
      bus.wb_ready = 1'b1;
      @(negedge clk);
      bus.wb_ready = 1'b0;
      tests_run++; if (bus.wb_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL ii_wb_req_drop got %b want 0", bus.wb_req); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests_run++; if (bus.tag_we !== 2'b00 || bus.cacop_complete !== 1'b0) begin tests_failed++; $display("[TB] FAIL ii_wait_idle got we=%b cpl=%b want 00/0", bus.tag_we, bus.cacop_complete); end
      end
      @(negedge clk);
      bus.wb_done = 1'b1;
      @(negedge clk);
      bus.wb_done = 1'b0;
      tests_run++; if (bus.tag_we !== 2'b01 || bus.tag_addr !== 6'd2) begin tests_failed++; $display("[TB] FAIL ii_tag_we got we=%b addr=%0d want 01/2", bus.tag_we, bus.tag_addr); end
      @(negedge clk);
      tests_run++; if (bus.cacop_complete !== 1'b1 || bus.cacop_exp !== 7'h00) begin tests_failed++; $display("[TB] FAIL ii_complete got cpl=%b exp=%h want 1/00", bus.cacop_complete, bus.cacop_exp); end
      @(negedge clk);
   endtask

   task automatic test_hit_inv_clean;
      int wb0;
      wb0 = n_wb_req;
      bus.tag_rdata = {1'b1, 1'b0, 20'h80000, 1'b1, 1'b1, 20'h12345};
      do_accept(2'd2, 32'h1000_0100);
      tests_run++; if (bus.tlb_req !== 1'b1 || bus.tlb_vaddr !== 32'h1000_0100) begin tests_failed++; $display("[TB] FAIL hit_tlb_req got req=%b va=%h want 1/10000100", bus.tlb_req, bus.tlb_vaddr); end
      @(negedge clk);
      tests_run++; if (bus.tlb_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL hit_tlb_hold got %b want 1", bus.tlb_req); end
      bus.tlb_valid = 1'b1; bus.tlb_paddr = 32'h8000_0100; bus.tlb_exp = 7'h00;
      @(negedge clk);
      bus.tlb_valid = 1'b0;
      tests_run++; if (bus.tag_rd !== 1'b1 || bus.tag_addr !== 6'd4 || bus.tlb_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL hit_tag_rd got rd=%b addr=%0d tlb=%b want 1/4/0", bus.tag_rd, bus.tag_addr, bus.tlb_req); end
      repeat (2) @(negedge clk);
      tests_run++; if (bus.tag_we !== 2'b10 || bus.tag_addr !== 6'd4) begin tests_failed++; $display("[TB] FAIL hit_tag_we got we=%b addr=%0d want 10/4", bus.tag_we, bus.tag_addr); end
      @(negedge clk);
      tests_run++; if (bus.cacop_complete !== 1'b1 || bus.cacop_exp !== 7'h00) begin tests_failed++; $display("[TB] FAIL hit_complete got cpl=%b exp=%h want 1/00", bus.cacop_complete, bus.cacop_exp); end
      @(negedge clk);
      tests_run++; if ((n_wb_req - wb0) !== 0) begin tests_failed++; $display("[TB] FAIL hit_no_wb got %0d want 0", n_wb_req - wb0); end
   endtask

   task automatic test_hit_priority;
      bus.tag_rdata = {1'b1, 1'b0, 20'h80000, 1'b1, 1'b0, 20'h80000};
      do_accept(2'd2, 32'h1000_0100);
      bus.tlb_valid = 1'b1; bus.tlb_paddr = 32'h8000_0100; bus.tlb_exp = 7'h00;
      @(negedge clk);
      bus.tlb_valid = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++; if (bus.tag_we !== 2'b01) begin tests_failed++; $display("[TB] FAIL prio_tag_we got %b want 01", bus.tag_we); end
      @(negedge clk);
      tests_run++; if (bus.cacop_complete !== 1'b1) begin tests_failed++; $display("[TB] FAIL prio_complete got %b want 1", bus.cacop_complete); end
      @(negedge clk);
   endtask

   task automatic test_hit_miss;
      int we0, wb0;
      we0 = n_tag_we; wb0 = n_wb_req;
      bus.tag_rdata = {1'b0, 1'b1, 20'h80000, 1'b1, 1'b0, 20'h7FFFF};
      do_accept(2'd2, 32'h1000_0100);
      bus.tlb_valid = 1'b1; bus.tlb_paddr = 32'h8000_0100; bus.tlb_exp = 7'h00;
      @(negedge clk);
      bus.tlb_valid = 1'b0;
      @(negedge clk);
      tests_run++; if (bus.cacop_complete !== 1'b0) begin tests_failed++; $display("[TB] FAIL miss_early_complete got %b want 0", bus.cacop_complete); end
      @(negedge clk);
      tests_run++; if (bus.cacop_complete !== 1'b1 || bus.cacop_exp !== 7'h00) begin tests_failed++; $display("[TB] FAIL miss_complete got cpl=%b exp=%h want 1/00", bus.cacop_complete, bus.cacop_exp); end
      @(negedge clk);
      tests_run++; if ((n_tag_we - we0) !== 0 || (n_wb_req - wb0) !== 0) begin tests_failed++; $display("[TB] FAIL miss_no_write got we=%0d wb=%0d want 0/0", n_tag_we - we0, n_wb_req - wb0); end
   endtask

   task automatic test_tlb_fault;
      int rd0;
      rd0 = n_tag_rd;
      do_accept(2'd2, 32'h2000_0040);
      bus.tlb_valid = 1'b1; bus.tlb_exp = 7'h09; bus.tlb_paddr = 32'h0;
      @(negedge clk);
      bus.tlb_valid = 1'b0; bus.tlb_exp = 7'h00;
      tests_run++; if (bus.cacop_complete !== 1'b1 || bus.cacop_exp !== 7'h09) begin tests_failed++; $display("[TB] FAIL fault_complete got cpl=%b exp=%h want 1/09", bus.cacop_complete, bus.cacop_exp); end
      @(negedge clk);
      tests_run++; if ((n_tag_rd - rd0) !== 0) begin tests_failed++; $display("[TB] FAIL fault_no_tag_rd got %0d want 0", n_tag_rd - rd0); end
      tests_run++; if (bus.cacop_exp !== 7'h00) begin tests_failed++; $display("[TB] FAIL fault_exp_idle got %h want 00", bus.cacop_exp); end
      do_accept(2'd3, 32'h0000_0000);
      tests_run++; if (bus.cacop_complete !== 1'b1 || bus.cacop_exp !== 7'h00) begin tests_failed++; $display("[TB] FAIL rsvd_after_fault got cpl=%b exp=%h want 1/00", bus.cacop_complete, bus.cacop_exp); end
      @(negedge clk);
   endtask

   task automatic test_reset_midflight;
      int we0;
      bus.tag_rdata = {1'b0, 1'b0, 20'h00000, 1'b1, 1'b1, 20'h12345};
      do_accept(2'd1, 32'h0000_0080);
      repeat (2) @(negedge clk);
      tests_run++; if (bus.wb_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_wb_req got %b want 1", bus.wb_req); end
      bus.wb_ready = 1'b1;
      @(negedge clk);
      bus.wb_ready = 1'b0;
      #2 rstn = 1'b0;
      #1;
      tests_run++; if ({bus.wb_req, bus.cacop_complete} !== 2'b00 || bus.tag_we !== 2'b00) begin tests_failed++; $display("[TB] FAIL mid_rst_outputs got wb=%b cpl=%b we=%b want 0/0/00", bus.wb_req, bus.cacop_complete, bus.tag_we); end
      tests_run++; if (bus.cacop_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_rst_ready got %b want 1", bus.cacop_ready); end
      @(negedge clk);
      rstn = 1'b1;
      we0 = n_tag_we;
      @(negedge clk);
      bus.wb_done = 1'b1;
      @(negedge clk);
      bus.wb_done = 1'b0;
      @(negedge clk);
      tests_run++; if ((n_tag_we - we0) !== 0 || bus.cacop_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_stray_done got we=%0d ready=%b want 0/1", n_tag_we - we0, bus.cacop_ready); end
      do_accept(2'd0, 32'h0000_0041);
      tests_run++; if (bus.tag_we !== 2'b10 || bus.tag_addr !== 6'd1) begin tests_failed++; $display("[TB] FAIL mid_st_tag_we got we=%b addr=%0d want 10/1", bus.tag_we, bus.tag_addr); end
      @(negedge clk);
      tests_run++; if (bus.cacop_complete !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_st_complete got %b want 1", bus.cacop_complete); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_store_tag();
      test_busy_ignore();
      test_index_inv_dirty();
      test_hit_inv_clean();
      test_hit_priority();
      test_hit_miss();
      test_tlb_fault();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
